// File: rtl/spart_driver.sv
// Loopback echo bus master for the SPART: programs the baud divisor, then moves received bytes
// through a small echo buffer back to the transmitter. `SPART_DRV_FIFO_EN selects a 4-entry buffer.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'h028A,
  parameter logic [15:0] DIV_9600  = 16'h0145,
  parameter logic [15:0] DIV_19200 = 16'h00A2,
  parameter logic [15:0] DIV_38400 = 16'h0051
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [2:0] fifo_level
);

  typedef enum logic [2:0] {INIT_LO, INIT_HI, POLL, RX_READ, TX_WRITE} state_t;

`ifdef SPART_DRV_FIFO_EN
  localparam logic [2:0] DEPTH = 3'd4;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  state_t      state, nxt;
  logic        run;
  logic [1:0]  br_s1, br_s2, prog_cfg;
  logic [15:0] divisor;
  logic [7:0]  dout, head;
  logic        drive, push, pop, latch_cfg;
  logic [2:0]  level;
  logic        full, empty;

  assign full    = (level == DEPTH);
  assign empty   = (level == 3'd0);
  assign databus = drive ? dout : 8'hzz;

  always_comb begin
    case (br_s2)
      2'b00:   divisor = DIV_4800;
      2'b01:   divisor = DIV_9600;
      2'b10:   divisor = DIV_19200;
      default: divisor = DIV_38400;
    endcase
  end

  // run holds the bus idle until the first edge after reset release, so INIT_LO starts there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT_LO;
      run      <= 1'b0;
      br_s1    <= 2'b01;
      br_s2    <= 2'b01;
      prog_cfg <= 2'b01;
    end else begin
      run   <= 1'b1;
      br_s1 <= br_cfg;
      br_s2 <= br_s1;
      if (run) state <= nxt;
      if (latch_cfg) prog_cfg <= br_s2;
    end
  end

  always_comb begin
    nxt       = state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b00;
    dout      = 8'h00;
    push      = 1'b0;
    pop       = 1'b0;
    latch_cfg = 1'b0;
    if (run) begin
      case (state)
        INIT_LO: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b10; dout = divisor[7:0];
          nxt  = INIT_HI;
        end
        INIT_HI: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; dout = divisor[15:8];
          latch_cfg = 1'b1;
          nxt  = POLL;
        end
        POLL: begin
          if (br_s2 != prog_cfg)  nxt = INIT_LO;
          else if (rda && !full)  nxt = RX_READ;
          else if (tbr && !empty) nxt = TX_WRITE;
        end
        RX_READ: begin
          iocs = 1'b1;
          push = 1'b1;
          nxt  = POLL;
        end
        TX_WRITE: begin
          iocs = 1'b1; iorw = 1'b0; dout = head;
          pop  = 1'b1;
          nxt  = POLL;
        end
        default: nxt = INIT_LO;
      endcase
    end
  end

  assign drive = iocs & ~iorw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      level <= 3'd0;
    else if (push) level <= level + 3'd1;
    else if (pop)  level <= level - 3'd1;
  end

`ifdef SPART_DRV_FIFO_EN
  logic [1:0] wr_ptr, rd_ptr;
  logic [7:0] mem [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

  assign head       = mem[rd_ptr];
  assign fifo_level = level;
`else
  logic [7:0] hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hold <= 8'h00;
    else if (push) hold <= databus;
  end

  assign head       = hold;
  assign fifo_level = {2'b00, level[0]};
`endif

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: init sequence, echo path, buffer-full handling,
// baud reprogramming and asynchronous reset; a simple SPART model answers reads.
module tb_spart_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda, tbr;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [2:0] fifo_level;
  logic [7:0] spart_data;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign databus = (iocs && iorw) ? spart_data : 8'hzz;

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bus state checks: idle POLL, read cycle, write cycle with data
  task automatic chk_poll(input string tag);
    check({tag, ".iocs"}, {7'd0, iocs}, 8'h00);
    check({tag, ".iorw"}, {7'd0, iorw}, 8'h01);
  endtask

  task automatic chk_rd(input string tag);
    check({tag, ".iocs"}, {7'd0, iocs}, 8'h01);
    check({tag, ".iorw"}, {7'd0, iorw}, 8'h01);
    check({tag, ".addr"}, {6'd0, ioaddr}, 8'h00);
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] a, input logic [7:0] d);
    check({tag, ".iocs"}, {7'd0, iocs}, 8'h01);
    check({tag, ".iorw"}, {7'd0, iorw}, 8'h00);
    check({tag, ".addr"}, {6'd0, ioaddr}, {6'd0, a});
    check({tag, ".data"}, databus, d);
  endtask

  // read one byte from the SPART into the buffer; leaves DUT in POLL after the read
  task automatic load(input logic [7:0] b, input logic [2:0] lvl_after);
    rda = 1'b1; spart_data = b;
    step(); chk_rd("load.rx");
    rda = 1'b0;
    step(); chk_poll("load.poll");
    check("load.lvl", {5'd0, fifo_level}, {5'd0, lvl_after});
  endtask

  // one echo transmit: TX_WRITE with byte b, then POLL
  task automatic echo(input logic [7:0] b, input logic [2:0] lvl_after);
    step(); chk_wr("echo.tx", 2'b00, b);
    step(); chk_poll("echo.poll");
    check("echo.lvl", {5'd0, fifo_level}, {5'd0, lvl_after});
  endtask

  initial begin
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; spart_data = 8'h00;
    #22;
    // reset state
    check("rst.iocs", {7'd0, iocs}, 8'h00);
    check("rst.iorw", {7'd0, iorw}, 8'h01);
    check("rst.addr", {6'd0, ioaddr}, 8'h00);
    check("rst.lvl", {5'd0, fifo_level}, 8'h00);
    @(negedge clk); rst = 1'b1;

    // divisor programming for 9600
    step(); chk_wr("init.lo", 2'b10, 8'h45);
    step(); chk_wr("init.hi", 2'b11, 8'h01);
    step(); chk_poll("init.poll");
    step(); chk_poll("init.idle");

    // single-byte echo
    rda = 1'b1; tbr = 1'b1; spart_data = 8'h5A;
    step(); chk_rd("e5a.rx");
    check("e5a.lvl0", {5'd0, fifo_level}, 8'h00);
    rda = 1'b0;
    step(); chk_poll("e5a.poll");
    check("e5a.lvl1", {5'd0, fifo_level}, 8'h01);
    echo(8'h5A, 3'd0);
    tbr = 1'b0;

`ifdef SPART_DRV_FIFO_EN
    // rda beats tbr while not full
    load(8'h11, 3'd1);
    rda = 1'b1; tbr = 1'b1; spart_data = 8'h22;
    step(); chk_rd("prio.rx");
    rda = 1'b0;
    step(); chk_poll("prio.poll");
    check("prio.lvl", {5'd0, fifo_level}, 8'h02);
    echo(8'h11, 3'd1);
    echo(8'h22, 3'd0);
    tbr = 1'b0;

    // fill to four, fifth rda waits for space
    for (int i = 1; i <= 4; i++) load(i[7:0], i[2:0]);
    rda = 1'b1; spart_data = 8'h05;
    step(); chk_poll("full.hold1");
    step(); chk_poll("full.hold2");
    check("full.lvl", {5'd0, fifo_level}, 8'h04);
    tbr = 1'b1;
    echo(8'h01, 3'd3);
    step(); chk_rd("full.rx5");
    rda = 1'b0;
    step(); chk_poll("full.poll5");
    check("full.lvl5", {5'd0, fifo_level}, 8'h04);
    for (int i = 2; i <= 5; i++) echo(i[7:0], 3'(5 - i));
    tbr = 1'b0;

    // reprogram with two bytes held
    load(8'hAA, 3'd1);
    load(8'hBB, 3'd2);
`else
    // single holding register: full at one byte, rda ignored until transmitted
    load(8'h11, 3'd1);
    rda = 1'b1; spart_data = 8'h22;
    step(); chk_poll("hold.full");
    tbr = 1'b1;
    echo(8'h11, 3'd0);
    step(); chk_rd("hold.rx");
    rda = 1'b0;
    step(); chk_poll("hold.poll");
    check("hold.lvl", {5'd0, fifo_level}, 8'h01);
    echo(8'h22, 3'd0);
    tbr = 1'b0;

    // reprogram with one byte held
    load(8'hAA, 3'd1);
`endif
    br_cfg = 2'b11;
    step(); chk_poll("rp.sync1");
    step(); chk_poll("rp.sync2");
    step(); chk_wr("rp.lo", 2'b10, 8'h51);
    step(); chk_wr("rp.hi", 2'b11, 8'h00);
    step(); chk_poll("rp.poll");
    tbr = 1'b1;
`ifdef SPART_DRV_FIFO_EN
    check("rp.lvl", {5'd0, fifo_level}, 8'h02);
    echo(8'hAA, 3'd1);
    echo(8'hBB, 3'd0);
`else
    check("rp.lvl", {5'd0, fifo_level}, 8'h01);
    echo(8'hAA, 3'd0);
`endif
    tbr = 1'b0;

    // asynchronous reset in the middle of a transmit
    load(8'h77, 3'd1);
    tbr = 1'b1;
    step(); chk_wr("ar.tx", 2'b00, 8'h77);
    #2 rst = 1'b0; br_cfg = 2'b01; tbr = 1'b0;
    #1;
    chk_poll("ar.async");
    check("ar.addr", {6'd0, ioaddr}, 8'h00);
    check("ar.lvl", {5'd0, fifo_level}, 8'h00);
    @(negedge clk); rst = 1'b1;
    step(); chk_wr("ar.lo", 2'b10, 8'h45);
    step(); chk_wr("ar.hi", 2'b11, 8'h01);
    step(); chk_poll("ar.poll");
    check("ar.lvl2", {5'd0, fifo_level}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spart_driver.md
# spart_driver

Bus master for the SPART serial port. Programs the baud divisor from a 2-bit board switch, polls the SPART handshake lines, reads received bytes over the shared 8-bit bidirectional databus, buffers them, and writes them back to the SPART transmit buffer, producing a loopback echo terminal. Sits directly above the SPART on the board: it is the only master that drives iocs/iorw/ioaddr/databus.

## Interface
- DIV_4800, 16'h028A: divisor for br_cfg=00.
- DIV_9600, 16'h0145: divisor for br_cfg=01.
- DIV_19200, 16'h00A2: divisor for br_cfg=10.
- DIV_38400, 16'h0051: divisor for br_cfg=11.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- br_cfg  in  2  baud select switches, asynchronous; 2-flop synchronised internally.
- rda  in  1  SPART receive data available.
- tbr  in  1  SPART transmit buffer ready.
- iocs  out  1  chip select; high only during a bus access cycle.
- iorw  out  1  1 = read (SPART drives databus), 0 = write (driver drives).
- ioaddr  out  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high.
- databus  inout  8  driven by this block only when iocs=1 and iorw=0, else Z.
- fifo_level  out  3  number of bytes held in the echo buffer (0..4).

## Operation
- States: INIT_LO, INIT_HI, POLL, RX_READ, TX_WRITE.
- INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0] → INIT_HI.
- INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; latch synchronised br_cfg as prog_cfg → POLL.
- Divisor selected by synchronised br_cfg via the four parameters.
- POLL: iocs=0, iorw=1, ioaddr=00. Priority, highest first:
  - synchronised br_cfg != prog_cfg → INIT_LO (buffer contents kept);
  - rda=1 and buffer not full → RX_READ;
  - tbr=1 and buffer not empty → TX_WRITE;
  - else stay.
- RX_READ: iocs=1, iorw=1, ioaddr=00; databus sampled at clock edge and pushed → POLL.
- TX_WRITE: iocs=1, iorw=0, ioaddr=00, databus=buffer head; head popped at edge → POLL.
- Every access state returns to POLL for at least one cycle; no back-to-back bus accesses.
- Buffer: circular, 2-bit read/write pointers wrap 3→0; fifo_level = write count − read count.
- Full: rda ignored; byte stays in SPART until space frees (no drop, no overwrite).
- Empty: tbr ignored.
- Push and pop never occur in the same cycle (mutually exclusive states).

## Timing
- Reset values: iocs=0, iorw=1, ioaddr=00, databus=Z, fifo_level=0, state=INIT_LO, pointers=0, prog_cfg=01.
- First rising edge after reset release is INIT_LO cycle; INIT_HI next; POLL from the third cycle.
- br_cfg change to reprogram start: 2 sync cycles + up to 1 cycle finishing current access.
- Echo latency: rda sampled high in POLL cycle N → RX_READ N+1 → POLL N+2 → TX_WRITE N+3 if tbr=1 and no newer rda.
- fifo_level updates the cycle after RX_READ/TX_WRITE.
- Reset asserted mid-access: outputs return to reset values immediately (asynchronous); databus released same instant; buffer emptied.

## Configuration
- SPART_DRV_FIFO_EN defined: 4-entry echo buffer as above; fifo_level ranges 0..4.
- Undefined: buffer is a single holding register (depth 1, full when 1 byte held); fifo_level ranges 0..1, upper bits tie to 0; all state/priority rules unchanged.

## Test plan
- Reset release with br_cfg=01 → cycle 1 ioaddr=10 databus=8'h45, cycle 2 ioaddr=11 databus=8'h01, both iocs=1 iorw=0; then iocs=0.
- rda pulse with SPART returning 8'h5A, tbr=1 → RX_READ then TX_WRITE drives 8'h5A on ioaddr=00; fifo_level 0→1→0.
- tbr held 0, five rda events with bytes 8'h01..8'h05 (FIFO enabled) → four reads, fifo_level=4, fifth rda not serviced until tbr=1; echo order 01,02,03,04,05.
- br_cfg switched 01→11 while buffer holds 2 bytes → reprogram writes 8'h51 then 8'h00; fifo_level stays 2; echo resumes.
- rda and tbr both high, buffer 1 byte, not full → RX_READ chosen before TX_WRITE.
- rst asserted during TX_WRITE → databus goes Z and iocs=0 without a clock edge; after release INIT sequence repeats, fifo_level=0.
